pipe_gap_scheduler: RTL and testbench

- Sequences the 5-bit Fibonacci LFSR and shares its output between two pipe-slot requesters.
- Each grant carries a range-limited vertical gap position for a new pipe.
- Sits between the free-running pipe scroller (requesters) and the LFSR. It steps the LFSR on demand, rejects out-of-range samples with bounded retries, and round-robins between slots.

---
 rtl/pipe_gap_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_pipe_gap_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_gap_scheduler.sv
// -----------------------------------------------------------------------------
// pipe_gap_scheduler
//
// Shares a 5-bit Fibonacci LFSR between two pipe-slot requesters. For each
// accepted request the scheduler steps the LFSR, samples it, and turns the
// sample into a vertical gap position inside [GAP_MIN, GAP_MIN+GAP_RANGE].
// Out-of-range samples are retried up to MAX_RETRY times, after which a
// fixed mid-range gap is issued so a grant is never withheld. The two slots
// are served round-robin.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   req[1:0]    level request per slot, held until its gnt bit is seen
//   pause       blocks new requests from being accepted while in IDLE
//   lfsr_step   one-cycle pulse; LFSR advances on the closing edge
//   lfsr_data   current LFSR value (valid the cycle after lfsr_step)
//   gnt[1:0]    one-hot, one-cycle grant pulse
//   gap_y[5:0]  gap position, valid with gnt, holds its value otherwise
//   reject_cnt  (only with GAP_STATS_EN) saturating count of rejected samples
//   lfsr_err    sticky flag, set when an all-zero LFSR value is sampled
//
// Optional feature macro: GAP_STATS_EN (adds reject_cnt[7:0]).
// -----------------------------------------------------------------------------
module pipe_gap_scheduler #(
    parameter int GAP_MIN   = 4,
    parameter int GAP_RANGE = 15,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       pause,
    output logic       lfsr_step,
    input  logic [4:0] lfsr_data,
    output logic [1:0] gnt,
    output logic [5:0] gap_y,
`ifdef GAP_STATS_EN
    output logic [7:0] reject_cnt,
`endif
    output logic       lfsr_err
);

    localparam int                 RETRY_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY);
    localparam logic [5:0]         GAP_BASE     = 6'(GAP_MIN);
    localparam logic [5:0]         GAP_LIMIT    = 6'(GAP_RANGE);
    localparam logic [5:0]         GAP_FALLBACK = 6'(GAP_MIN + (GAP_RANGE >> 1));

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SAMPLE,
        GRANT
    } state_t;

    state_t             state_q,  state_d;
    logic [RETRY_W-1:0] retry_q,  retry_d;
    logic               rr_q,     rr_d;
    logic               winner_q, winner_d;
    logic [1:0]         gnt_q,    gnt_d;
    logic               step_q,   step_d;
    logic [5:0]         gap_q,    gap_d;
    logic               err_q,    err_d;
`ifdef GAP_STATS_EN
    logic [7:0]         rej_q,    rej_d;
`endif

    logic [4:0] offset;
    logic       sample_ok;
    logic [1:0] winner_onehot;

    // A zero sample wraps the offset to 31, but it is rejected explicitly
    // anyway so the range check never has to reason about the wrap.
    always_comb begin
        offset        = lfsr_data - 5'd1;
        sample_ok     = (lfsr_data != 5'd0) && ({1'b0, offset} <= GAP_LIMIT);
        winner_onehot = winner_q ? 2'b10 : 2'b01;
    end

    // Next-state logic. Outputs are computed one cycle ahead so that
    // lfsr_step and gnt come straight from flops.
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        rr_d     = rr_q;
        winner_d = winner_q;
        gnt_d    = 2'b00;
        step_d   = 1'b0;
        gap_d    = gap_q;
        err_d    = err_q;
`ifdef GAP_STATS_EN
        rej_d    = rej_q;
`endif

        case (state_q)
            IDLE: begin
                retry_d = '0;
                if (!pause && (req != 2'b00)) begin
                    // Pointer slot wins if it asks; otherwise the other one must be asking.
                    winner_d = req[rr_q] ? rr_q : ~rr_q;
                    state_d  = STEP;
                    step_d   = 1'b1;
                end
            end

            STEP: begin
                state_d = SAMPLE;
            end

            SAMPLE: begin
                if (lfsr_data == 5'd0) begin
                    err_d = 1'b1;
                end
`ifdef GAP_STATS_EN
                if (!sample_ok && (rej_q != 8'hFF)) begin
                    rej_d = rej_q + 8'd1;
                end
`endif
                if (sample_ok) begin
                    gap_d   = GAP_BASE + {1'b0, offset};
                    gnt_d   = winner_onehot;
                    state_d = GRANT;
                end else if (retry_q < RETRY_LAST) begin
                    retry_d = retry_q + 1'b1;
                    step_d  = 1'b1;
                    state_d = STEP;
                end else begin
                    gap_d   = GAP_FALLBACK;
                    gnt_d   = winner_onehot;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                rr_d    = ~winner_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            retry_q  <= '0;
            rr_q     <= 1'b0;
            winner_q <= 1'b0;
            gnt_q    <= 2'b00;
            step_q   <= 1'b0;
            gap_q    <= 6'd0;
            err_q    <= 1'b0;
`ifdef GAP_STATS_EN
            rej_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            rr_q     <= rr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            step_q   <= step_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
`ifdef GAP_STATS_EN
            rej_q    <= rej_d;
`endif
        end
    end

    assign lfsr_step = step_q;
    assign gnt       = gnt_q;
    assign gap_y     = gap_q;
    assign lfsr_err  = err_q;
`ifdef GAP_STATS_EN
    assign reject_cnt = rej_q;
`endif

endmodule

// File: tb/tb_pipe_gap_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pipe_gap_scheduler
//
// Self-checking bench for pipe_gap_scheduler: reset behaviour, a table of
// single-request transactions, hand-written arbitration / pause / mid-run
// reset sequences, and a randomized run against a transaction-level model.
// Cycle n below is the clock period that follows rising edge n-1; inputs
// are driven and outputs observed on the falling edge inside that period.
// -----------------------------------------------------------------------------
module tb_pipe_gap_scheduler;

    localparam int GAP_MIN   = 4;
    localparam int GAP_RANGE = 15;
    localparam int MAX_RETRY = 3;
    localparam int RAND_CYCLES = 3000;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       pause;
    logic       lfsr_step;
    logic [4:0] lfsr_data;
    logic [1:0] gnt;
    logic [5:0] gap_y;
    logic       lfsr_err;
`ifdef GAP_STATS_EN
    logic [7:0] reject_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_gap_scheduler #(
        .GAP_MIN   (GAP_MIN),
        .GAP_RANGE (GAP_RANGE),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .pause      (pause),
        .lfsr_step  (lfsr_step),
        .lfsr_data  (lfsr_data),
        .gnt        (gnt),
        .gap_y      (gap_y),
`ifdef GAP_STATS_EN
        .reject_cnt (reject_cnt),
`endif
        .lfsr_err   (lfsr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string           name;
        logic [1:0]      req;
        logic [3:0][4:0] samp;
        int              nsamp;
        logic [1:0]      exp_gnt;
        int              exp_cycle;
        logic [5:0]      exp_gap;
        logic            exp_err;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mkVec(string name, logic [1:0] r, int s0, int s1, int s2, int s3,
                                   int n, logic [1:0] g, int cyc, int gap, logic err);
        vec_t v;
        v.name      = name;
        v.req       = r;
        v.samp[0]   = 5'(s0);
        v.samp[1]   = 5'(s1);
        v.samp[2]   = 5'(s2);
        v.samp[3]   = 5'(s3);
        v.nsamp     = n;
        v.exp_gnt   = g;
        v.exp_cycle = cyc;
        v.exp_gap   = 6'(gap);
        v.exp_err   = err;
        return v;
    endfunction

    task automatic applyStimulus(input logic [1:0] r, input logic p, input logic [4:0] d);
        req       = r;
        pause     = p;
        lfsr_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Leaves the bench on a falling edge with rst_n just released: cycle 0.
    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runVector(input vec_t v);
        int steps, gcyc, extra, idx;
        logic [1:0] gval;
        logic [5:0] gseen;
        resetDut();
        applyStimulus(v.req, 1'b0, 5'd0);
        steps = 0; gcyc = -1; extra = 0; idx = 0; gval = 2'b00; gseen = 6'd0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (lfsr_step) begin
                steps++;
                lfsr_data = (idx < 4) ? v.samp[idx] : 5'd31;
                idx++;
            end
            if (gnt != 2'b00) begin
                if (gcyc < 0) begin
                    gcyc  = n;
                    gval  = gnt;
                    gseen = gap_y;
                end else begin
                    extra++;
                end
                req = 2'b00;
            end
        end
        checkOutput({v.name, "_steps"}, steps, v.nsamp);
        checkOutput({v.name, "_gnt_cycle"}, gcyc, v.exp_cycle);
        checkOutput({v.name, "_gnt"}, gval, v.exp_gnt);
        checkOutput({v.name, "_gap"}, gseen, v.exp_gap);
        checkOutput({v.name, "_gap_hold"}, gap_y, v.exp_gap);
        checkOutput({v.name, "_err"}, lfsr_err, v.exp_err);
        checkOutput({v.name, "_extra_gnt"}, extra, 0);
    endtask

    // Randomized-run model state
    logic       pend[2];
    logic [1:0] pend_v;
    logic [1:0] drop;
    logic       in_flight, w, rr_m, acc, p;
    int         t0, k, rel, err_from, v;
    logic [4:0] samp[MAX_RETRY+1];
    logic [4:0] d;
    logic [5:0] gap_m, exp_gap;
    logic [1:0] exp_gnt;
    logic       exp_step, exp_err;
    int         cnt_step, cnt_gnt;
    logic [1:0] arb_exp_gnt;
    logic       arb_exp_step;

    initial begin
        vecs[0] = mkVec("accept",        2'b01,  5,  0,  0,  0, 1, 2'b01, 3,  8, 1'b0);
        vecs[1] = mkVec("retries",       2'b01, 20, 25, 17,  9, 4, 2'b01, 9, 12, 1'b0);
        vecs[2] = mkVec("exhaust",       2'b10, 31, 31, 31, 31, 4, 2'b10, 9, 11, 1'b0);
        vecs[3] = mkVec("lockup",        2'b01,  0,  2,  0,  0, 2, 2'b01, 5,  5, 1'b1);
        vecs[4] = mkVec("gap_min",       2'b10,  1,  0,  0,  0, 1, 2'b10, 3,  4, 1'b0);
        vecs[5] = mkVec("gap_max",       2'b01, 16,  0,  0,  0, 1, 2'b01, 3, 19, 1'b0);
        vecs[6] = mkVec("over_by_one",   2'b10, 17, 16,  0,  0, 2, 2'b10, 5, 19, 1'b0);
        vecs[7] = mkVec("exhaust_zeros", 2'b01,  0,  0,  0,  0, 4, 2'b01, 9, 11, 1'b1);

        // Reset held with both slots requesting
        rst_n = 1'b0;
        applyStimulus(2'b11, 1'b0, 5'd5);
        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_step", lfsr_step, 0);
        checkOutput("rst_gap", gap_y, 0);
        checkOutput("rst_err", lfsr_err, 0);
`ifdef GAP_STATS_EN
        checkOutput("rst_reject_cnt", reject_cnt, 0);
`endif
        rst_n = 1'b1;
        applyStimulus(2'b00, 1'b0, 5'd5);
        cnt_step = 0; cnt_gnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (lfsr_step) cnt_step++;
            if (gnt != 2'b00) cnt_gnt++;
        end
        checkOutput("idle_no_step", cnt_step, 0);
        checkOutput("idle_no_gnt", cnt_gnt, 0);

        // Single-request transactions
        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i]);
        end

        // Arbitration and pause: both slots ask, then both again, then pause
        resetDut();
        applyStimulus(2'b11, 1'b0, 5'd3);
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            case (n)
                3, 12:   arb_exp_gnt = 2'b01;
                7, 21:   arb_exp_gnt = 2'b10;
                default: arb_exp_gnt = 2'b00;
            endcase
            arb_exp_step = (n == 1) || (n == 5) || (n == 10) || (n == 19);
            checkOutput($sformatf("arb_gnt_c%0d", n), gnt, arb_exp_gnt);
            checkOutput($sformatf("arb_step_c%0d", n), lfsr_step, arb_exp_step);
            if (n == 3) checkOutput("arb_gap", gap_y, 6);
            if (gnt[0]) req[0] = 1'b0;
            if (gnt[1]) req[1] = 1'b0;
            if (n == 9)  req = 2'b11;
            if (n == 12) pause = 1'b1;
            if (n == 18) pause = 1'b0;
        end

        // Reset pulse during a STEP cycle aborts the request
        resetDut();
        applyStimulus(2'b01, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("midrst_step_before", lfsr_step, 1);
        checkOutput("midrst_err_before", lfsr_err, 1);
        rst_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 5'd0);
        #1;
        checkOutput("midrst_err", lfsr_err, 0);
        checkOutput("midrst_step", lfsr_step, 0);
        checkOutput("midrst_gnt", gnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_step = 0; cnt_gnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (lfsr_step) cnt_step++;
            if (gnt != 2'b00) cnt_gnt++;
        end
        checkOutput("midrst_no_step_after", cnt_step, 0);
        checkOutput("midrst_no_gnt_after", cnt_gnt, 0);
        applyStimulus(2'b01, 1'b0, 5'd5);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 3) begin
                checkOutput("midrst_regrant_gnt", gnt, 2'b01);
                checkOutput("midrst_regrant_gap", gap_y, 8);
            end
        end

        // Randomized run against a transaction-level model
        resetDut();
        pend[0] = 1'b0; pend[1] = 1'b0;
        in_flight = 1'b0; rr_m = 1'b0; w = 1'b0;
        t0 = 0; k = 0; err_from = -1;
        gap_m = 6'd0; exp_gap = 6'd0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if (c > 0) @(negedge clk);
            rel      = c - t0;
            exp_step = in_flight && (rel >= 1) && (rel <= 2 * k - 1) && (rel % 2 == 1);
            exp_gnt  = (in_flight && (rel == 2 * k + 1)) ? (w ? 2'b10 : 2'b01) : 2'b00;
            if (exp_gnt != 2'b00) exp_gap = gap_m;
            exp_err  = (err_from >= 0) && (c >= err_from);
            checkOutput("rand_gnt", gnt, exp_gnt);
            checkOutput("rand_step", lfsr_step, exp_step);
            checkOutput("rand_gap", gap_y, exp_gap);
            checkOutput("rand_err", lfsr_err, exp_err);

            // A granted requester lowers its bit in the cycle after the grant
            drop = 2'b00;
            if (in_flight && (rel == 2 * k + 2)) begin
                pend[w]   = 1'b0;
                drop[w]   = 1'b1;
                in_flight = 1'b0;
            end
            for (int s = 0; s < 2; s++) begin
                if (!pend[s] && !drop[s] && ($urandom_range(0, 3) == 0)) pend[s] = 1'b1;
            end
            p = ($urandom_range(0, 5) == 0);
            if (in_flight && (rel >= 2) && (rel % 2 == 0) && (rel / 2 <= k)) begin
                d = samp[rel / 2 - 1];
            end else begin
                d = 5'($urandom_range(0, 31));
            end
            pend_v = {pend[1], pend[0]};
            applyStimulus(pend_v, p, d);

            if (!in_flight && !p && (pend_v != 2'b00)) begin
                w   = pend[rr_m] ? rr_m : ~rr_m;
                t0  = c;
                k   = 0;
                acc = 1'b0;
                while ((k < MAX_RETRY + 1) && !acc) begin
                    v = ($urandom_range(0, 99) == 0) ? 0 : int'($urandom_range(1, 31));
                    samp[k] = 5'(v);
                    k++;
                    if (v == 0) begin
                        if (err_from < 0) err_from = t0 + 2 * k + 1;
                    end else if (v - 1 <= GAP_RANGE) begin
                        acc   = 1'b1;
                        gap_m = 6'(GAP_MIN + v - 1);
                    end
                end
                if (!acc) gap_m = 6'(GAP_MIN + GAP_RANGE / 2);
                rr_m      = ~w;
                in_flight = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
